// File: rtl/vga_timing_pkg.sv
// Shared timing constants, coordinate type and controller state encoding for
// the VGA timing controller. The defaults describe 640x480 at 60 Hz from a
// 100 MHz system clock.
package vga_timing_pkg;

    localparam int H_VIS_DEF = 640;
    localparam int H_FP_DEF  = 16;
    localparam int H_SW_DEF  = 96;
    localparam int H_BP_DEF  = 48;
    localparam int V_VIS_DEF = 480;
    localparam int V_FP_DEF  = 10;
    localparam int V_SW_DEF  = 2;
    localparam int V_BP_DEF  = 33;
    localparam int DIV_DEF   = 4;

    localparam int H_TOT_DEF = H_VIS_DEF + H_FP_DEF + H_SW_DEF + H_BP_DEF;
    localparam int V_TOT_DEF = V_VIS_DEF + V_FP_DEF + V_SW_DEF + V_BP_DEF;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Half-open window test used by the sync decoders: lo <= pos < hi.
    function automatic logic in_window(coord_t pos, coord_t lo, coord_t hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Video timing bundle between the timing controller (master) and its
// consumer (slave). frame_count exists only when VGA_FRAME_CNT_EN is defined.
interface vga_timing_ctrl_if;

    logic                   enable;
    logic                   pix_tick;
    logic                   hsync;
    logic                   vsync;
    logic                   video_on;
    vga_timing_pkg::coord_t pixel_x;
    vga_timing_pkg::coord_t pixel_y;
    logic                   frame_start;
    logic                   busy;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0]            frame_count;
`endif

    modport master (
`ifdef VGA_FRAME_CNT_EN
        output frame_count,
`endif
        input  enable,
        output pix_tick,
        output hsync,
        output vsync,
        output video_on,
        output pixel_x,
        output pixel_y,
        output frame_start,
        output busy
    );

    modport slave (
`ifdef VGA_FRAME_CNT_EN
        input  frame_count,
`endif
        output enable,
        input  pix_tick,
        input  hsync,
        input  vsync,
        input  video_on,
        input  pixel_x,
        input  pixel_y,
        input  frame_start,
        input  busy
    );

endinterface

// File: rtl/vga_pix_tick.sv
// Pixel-rate strobe: a 0..DIV-1 counter that free-runs while run is high and
// is parked at 0 otherwise, so the first strobe after start lands DIV clocks in.
module vga_pix_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic pix_tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next divider count: wrap at DIV-1, clear whenever the timing is stopped.
    always_comb begin
        cnt_d = cnt_q;
        if (!run) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Divider count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pix_tick = run && (cnt_q == LAST);

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing controller: pixel/line counters, sync and visibility decode,
// and a run/drain sequencer that always lets a started frame finish.
// Optional: define VGA_FRAME_CNT_EN to add a 16-bit frame_count output.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | timing stopped, counters parked at 0, syncs inactive
// ST_RUN   | enable high, frames repeat continuously
// ST_DRAIN | enable dropped, finishing current frame before going idle
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int H_VIS = H_VIS_DEF,
    parameter int H_FP  = H_FP_DEF,
    parameter int H_SW  = H_SW_DEF,
    parameter int H_BP  = H_BP_DEF,
    parameter int V_VIS = V_VIS_DEF,
    parameter int V_FP  = V_FP_DEF,
    parameter int V_SW  = V_SW_DEF,
    parameter int V_BP  = V_BP_DEF,
    parameter int DIV   = DIV_DEF
) (
    input logic               clk,
    input logic               reset,
    vga_timing_ctrl_if.master bus
);

    // Totals must fit the 10-bit coordinate type (H_TOT, V_TOT <= 1024).
    localparam coord_t H_LAST  = coord_t'(H_VIS + H_FP + H_SW + H_BP - 1);
    localparam coord_t V_LAST  = coord_t'(V_VIS + V_FP + V_SW + V_BP - 1);
    localparam coord_t H_VIS_C = coord_t'(H_VIS);
    localparam coord_t V_VIS_C = coord_t'(V_VIS);
    localparam coord_t HS_BEG  = coord_t'(H_VIS + H_FP);
    localparam coord_t HS_END  = coord_t'(H_VIS + H_FP + H_SW);
    localparam coord_t VS_BEG  = coord_t'(V_VIS + V_FP);
    localparam coord_t VS_END  = coord_t'(V_VIS + V_FP + V_SW);

    state_t state_q, state_d;
    coord_t h_q, h_d;
    coord_t v_q, v_d;
    logic   hsync_q, hsync_d;
    logic   vsync_q, vsync_d;
    logic   video_on_q, video_on_d;

    logic   run;
    logic   pix_tick;
    logic   frame_wrap;
    logic   frame_start;

    assign run = (state_q != ST_IDLE);

    vga_pix_tick #(
        .DIV (DIV)
    ) u_pix_tick (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .pix_tick (pix_tick)
    );

    assign frame_wrap  = pix_tick && (h_q == H_LAST) && (v_q == V_LAST);
    assign frame_start = pix_tick && (h_q == '0) && (v_q == '0);

    // Sequencer next state. In DRAIN the enable level wins over the frame wrap,
    // so a re-raise on the wrap clock keeps the timing running.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (bus.enable) state_d = ST_RUN;
            ST_RUN:   if (!bus.enable) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (bus.enable) begin
                    state_d = ST_RUN;
                end else if (frame_wrap) begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Next counters and the sync/visibility decode of the next position, so the
    // registered flags line up with the registered coordinates.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (pix_tick) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
        if (state_d == ST_IDLE) begin
            h_d = '0;
            v_d = '0;
        end

        hsync_d    = 1'b1;
        vsync_d    = 1'b1;
        video_on_d = 1'b0;
        if (state_d != ST_IDLE) begin
            hsync_d    = !in_window(h_d, HS_BEG, HS_END);
            vsync_d    = !in_window(v_d, VS_BEG, VS_END);
            video_on_d = (h_d < H_VIS_C) && (v_d < V_VIS_C);
        end
    end

    // State, counter and decoded-output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            h_q        <= '0;
            v_q        <= '0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            video_on_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            h_q        <= h_d;
            v_q        <= v_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            video_on_q <= video_on_d;
        end
    end

    assign bus.pix_tick    = pix_tick;
    assign bus.frame_start = frame_start;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.video_on    = video_on_q;
    assign bus.pixel_x     = h_q;
    assign bus.pixel_y     = v_q;
    assign bus.busy        = run;

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_count_q;

    // Frame counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count_q <= '0;
        end else if (frame_start) begin
            frame_count_q <= frame_count_q + 16'd1;
        end
    end

    assign bus.frame_count = frame_count_q;
`endif

endmodule
